instr_mem_loader: RTL and testbench
===================================

// Module: instr_mem_loader
// PURPOSE
//  Writer side of the instruction memory: fills it before the fetch stage runs.
//  Takes a byte stream over a valid/ready handshake and packs each 4 bytes into a big-endian word.
//  Writes each word to instruction memory at a word index.
//  Holds the fetch stage in reset (fetch_hold) until the programmed word count is stored.
// PARAMETERS
//  DEPTH      6             instruction memory depth in words; the load length is clamped to this
//  BASE_ADDR  32'h0040_0000 byte address of the first word; reported on load_base_addr
//  IDX_W      $clog2(DEPTH) width of the word index
// PORTS
//  clk             in   1      rising-edge clock
//  rst             in   1      asynchronous, active-low reset
//  start           in   1      1-cycle pulse that begins a load; sampled only in IDLE
//  num_words       in   IDX_W+1 words to load, sampled with start; 0 means finish at once
//  in_valid        in   1      byte available
//  in_data         in   8      byte value
//  in_ready        out  1      loader accepts a byte this cycle
//  mem_we          out  1      instruction memory write strobe
//  mem_idx         out  IDX_W  word index to write
//  mem_wdata       out  32     word to write
//  busy            out  1      a load is in progress
//  done            out  1      1-cycle pulse when the load completes
//  fetch_hold      out  1      keeps the fetch-stage reset asserted (1 = hold)
//  load_base_addr  out  32     constant BASE_ADDR, used by fetch to compute its offset
// BEHAVIOUR
//  Reset (rst=0, asynchronous):
//   - state=IDLE
//   - in_ready=0, mem_we=0, mem_idx=0, mem_wdata=0, busy=0, done=0
//   - fetch_hold=1
//   - byte counter and word counter cleared
//  FSM states: IDLE, COLLECT, WRITE, FINISH.
//   IDLE:
//    - start=1 latches target = min(num_words, DEPTH).
//    - target==0 -> FINISH; otherwise -> COLLECT with in_ready=1 the next cycle.
//   COLLECT:
//    - in_ready=1. A byte transfers when in_valid && in_ready.
//    - Bytes shift into word[31:0], MSB first: byte0 -> [31:24] ... byte3 -> [7:0].
//    - On the 4th accepted byte: -> WRITE, and in_ready drops in that same cycle's next edge.
//   WRITE (exactly 1 cycle):
//    - mem_we=1, mem_idx=word counter, mem_wdata=packed word.
//    - in_ready=0; in_valid is ignored.
//    - Word counter +1, byte counter cleared.
//    - Counter == target -> FINISH; otherwise -> COLLECT.
//   FINISH (1 cycle):
//    - done=1.
//    - fetch_hold falls to 0 on the next edge and stays 0 until a new start or reset.
//    - -> IDLE.
//  Registered outputs; throughput is 1 word per 5 cycles with in_valid held high.
//  busy=1 in COLLECT, WRITE and FINISH.
//  start while busy is ignored; no restart and no error.
//  A new start from IDLE after a completed load re-asserts fetch_hold=1 the cycle after start.
//  Gaps in in_valid stall COLLECT indefinitely; partial bytes are kept.
//  Reset mid-load abandons the partial word; words already written stay in memory.
//  Word counter never exceeds DEPTH-1 on mem_idx; the clamp guarantees this.
//  Fetch byte address of word i = BASE_ADDR + 4*i.
// TESTING
//  1. Reset -> in_ready=0, mem_we=0, busy=0, done=0, fetch_hold=1.
//  2. start with num_words=2, bytes 8C 01 00 04 AC 02 00 08 streamed back-to-back
//     -> mem_we at idx0=32'h8C010004 and idx1=32'hAC020008
//     -> done pulse on the cycle after the 2nd write, then fetch_hold=0.
//  3. num_words=1 with in_valid toggled every other cycle (bytes 12 34 56 78)
//     -> exactly one write, 32'h12345678 at idx0; no byte lost or duplicated.
//  4. num_words=9 (DEPTH=6) -> exactly 6 writes, idx 0..5, then done.
//     - start pulsed mid-load -> no effect.
//  5. rst pulled low after 2 bytes of word 1, then released; then start num_words=1 with bytes DE AD BE EF
//     -> outputs reset immediately on rst
//     -> single write 32'hDEADBEEF at idx0.
//  6. num_words=0 -> no mem_we; done 2 cycles after start; fetch_hold=0.

Source files
------------

// File: rtl/instr_mem_loader.sv
// instr_mem_loader: packs a byte stream into big-endian words, writes them to instruction memory
// and holds the fetch stage in reset until the requested word count is stored.
module instr_mem_loader #(
    parameter int          DEPTH     = 6,
    parameter logic [31:0] BASE_ADDR = 32'h0040_0000,
    parameter int          IDX_W     = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [IDX_W:0]   num_words_i,
    input  logic             in_valid_i,
    input  logic [7:0]       in_data_i,
    output logic             in_ready_o,
    output logic             mem_we_o,
    output logic [IDX_W-1:0] mem_idx_o,
    output logic [31:0]      mem_wdata_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             fetch_hold_o,
    output logic [31:0]      load_base_addr_o
);
    typedef enum logic [1:0] {IDLE, COLLECT, WRITE, FINISH} state_e;
    localparam logic [IDX_W:0] DEPTH_W = (IDX_W+1)'(DEPTH);
    state_e         state_q, state_d;
    logic [IDX_W:0] target_q, target_d, word_cnt_q, word_cnt_d, clamp;
    logic [1:0]     byte_cnt_q, byte_cnt_d;
    logic [31:0]    word_q, word_d;
    logic           hold_q, hold_d;
    assign clamp = (num_words_i > DEPTH_W) ? DEPTH_W : num_words_i;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            target_q   <= '0;
            word_cnt_q <= '0;
            byte_cnt_q <= '0;
            word_q     <= '0;
            hold_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            target_q   <= target_d;
            word_cnt_q <= word_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            word_q     <= word_d;
            hold_q     <= hold_d;
        end
    end
    always_comb begin
        state_d    = state_q;
        target_d   = target_q;
        word_cnt_d = word_cnt_q;
        byte_cnt_d = byte_cnt_q;
        word_d     = word_q;
        hold_d     = hold_q;
        case (state_q)
            IDLE: if (start_i) begin
                target_d   = clamp;
                word_cnt_d = '0;
                byte_cnt_d = '0;
                hold_d     = 1'b1;
                state_d    = (clamp == '0) ? FINISH : COLLECT;
            end
            COLLECT: if (in_valid_i) begin
                // shift left so the first byte of the group lands in [31:24]
                word_d     = {word_q[23:0], in_data_i};
                byte_cnt_d = byte_cnt_q + 2'd1;
                state_d    = (byte_cnt_q == 2'd3) ? WRITE : COLLECT;
            end
            WRITE: begin
                word_cnt_d = word_cnt_q + 1'b1;
                byte_cnt_d = '0;
                state_d    = (word_cnt_q + 1'b1 == target_q) ? FINISH : COLLECT;
            end
            FINISH: begin
                hold_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end
    assign in_ready_o       = state_q == COLLECT;
    assign mem_we_o         = state_q == WRITE;
    assign mem_idx_o        = word_cnt_q[IDX_W-1:0];
    assign mem_wdata_o      = word_q;
    assign busy_o           = state_q != IDLE;
    assign done_o           = state_q == FINISH;
    assign fetch_hold_o     = hold_q;
    assign load_base_addr_o = BASE_ADDR;
endmodule

// File: tb/tb_instr_mem_loader.sv
// tb_instr_mem_loader: scoreboard bench; a word-level model queues expected writes and done pulses,
// a negedge monitor pops and compares whatever the loader presents.
module tb_instr_mem_loader;
    localparam int DEPTH = 6;
    localparam int IDX_W = 3;
    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [IDX_W:0]   num_words = '0;
    logic             in_valid = 1'b0;
    logic [7:0]       in_data = '0;
    logic             in_ready, mem_we, busy, done, fetch_hold;
    logic [IDX_W-1:0] mem_idx;
    logic [31:0]      mem_wdata, base_addr;
    int               tests = 0;
    int               failed = 0;
    int               exp_idx[$];
    logic [31:0]      exp_data[$];
    bit               exp_done[$];
    logic             prev_we = 1'b0;

    instr_mem_loader #(.DEPTH(DEPTH), .BASE_ADDR(32'h0040_0000)) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .num_words_i(num_words),
        .in_valid_i(in_valid), .in_data_i(in_data), .in_ready_o(in_ready),
        .mem_we_o(mem_we), .mem_idx_o(mem_idx), .mem_wdata_o(mem_wdata),
        .busy_o(busy), .done_o(done), .fetch_hold_o(fetch_hold),
        .load_base_addr_o(base_addr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    // Word-level reference: word i is bytes 4i..4i+3 big-endian, for i below min(n, DEPTH).
    task automatic expect_load(input int n, input logic [7:0] bq[$]);
        int ne = (n > DEPTH) ? DEPTH : n;
        for (int i = 0; i < ne; i++) begin
            exp_idx.push_back(i);
            exp_data.push_back({bq[4*i], bq[4*i+1], bq[4*i+2], bq[4*i+3]});
        end
        exp_done.push_back(ne > 0);
    endtask

    task automatic gen(input int nb, output logic [7:0] q[$]);
        q = {};
        for (int i = 0; i < nb; i++) q.push_back(8'($urandom));
    endtask

    task automatic start_load(input int n);
        @(negedge clk);
        start = 1'b1;
        num_words = (IDX_W+1)'(n);
        @(negedge clk);
        start = 1'b0;
        chk("hold_after_start", {31'd0, fetch_hold}, 32'd1);
        chk("busy_after_start", {31'd0, busy}, 32'd1);
    endtask

    // mode 0: valid held high, 1: random gaps, 2: valid toggles every other cycle
    task automatic drive(input logic [7:0] bq[$], input int mode, input int poke);
        int  i = 0;
        int  cyc = 0;
        bit  poked = 0;
        while (i < bq.size() && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (i == poke && !poked) begin
                start = 1'b1;
                num_words = 1;
                poked = 1;
            end
            if (mode == 2 ? (cyc % 2) == 0 : mode == 1 ? $urandom_range(0, 2) == 0 : 1'b0) in_valid = 1'b0;
            else begin
                in_valid = 1'b1;
                in_data = bq[i];
                if (in_ready) i++;
            end
        end
        if (i < bq.size()) chk("drive_timeout", i, bq.size());
        @(negedge clk);
        in_valid = 1'b0;
        start = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!done && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("done_seen", {31'd0, done}, 32'd1);
        @(negedge clk);
        chk("hold_released", {31'd0, fetch_hold}, 32'd0);
        chk("idle_after_done", {31'd0, busy}, 32'd0);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_we) begin
                chk("busy_on_write", {31'd0, busy}, 32'd1);
                if (exp_data.size() == 0) begin
                    tests++;
                    failed++;
                    $display("FAIL unexpected_write: got idx %0d data %h, required no write", mem_idx, mem_wdata);
                end else begin
                    chk("write_idx", {29'd0, mem_idx}, exp_idx.pop_front());
                    chk("write_data", mem_wdata, exp_data.pop_front());
                end
            end
            if (done) begin
                if (exp_done.size() == 0) begin
                    tests++;
                    failed++;
                    $display("FAIL unexpected_done: got done=1, required 0");
                end else begin
                    if (exp_done.pop_front()) chk("done_after_write", {31'd0, prev_we}, 32'd1);
                    chk("writes_before_done", exp_data.size(), 0);
                end
            end
            prev_we <= mem_we;
        end else prev_we <= 1'b0;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        logic [7:0] bq[$];
        logic [7:0] part[$];
        int         cyc, n;
        #12;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_fetch_hold", {31'd0, fetch_hold}, 32'd1);
        chk("rst_mem_idx", {29'd0, mem_idx}, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("base_addr", base_addr, 32'h0040_0000);
        @(negedge clk);
        rst_n = 1'b1;
        bq = '{8'h8C, 8'h01, 8'h00, 8'h04, 8'hAC, 8'h02, 8'h00, 8'h08};
        expect_load(2, bq);
        start_load(2);
        drive(bq, 0, -1);
        wait_done(cyc);
        bq = '{8'h12, 8'h34, 8'h56, 8'h78};
        expect_load(1, bq);
        start_load(1);
        drive(bq, 2, -1);
        wait_done(cyc);
        gen(24, bq);
        expect_load(9, bq);
        start_load(9);
        drive(bq, 1, 10);
        wait_done(cyc);
        gen(12, bq);
        exp_idx.push_back(0);
        exp_data.push_back({bq[0], bq[1], bq[2], bq[3]});
        start_load(3);
        part = {};
        for (int i = 0; i < 6; i++) part.push_back(bq[i]);
        drive(part, 0, -1);
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_fetch_hold", {31'd0, fetch_hold}, 32'd1);
        chk("midrst_word0_written", exp_data.size(), 0);
        @(negedge clk);
        rst_n = 1'b1;
        bq = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        expect_load(1, bq);
        start_load(1);
        drive(bq, 1, -1);
        wait_done(cyc);
        bq = {};
        expect_load(0, bq);
        start_load(0);
        wait_done(cyc);
        chk("zero_done_in_time", {31'd0, cyc <= 2}, 32'd1);
        for (int r = 0; r < 8; r++) begin
            n = $urandom_range(0, 9);
            gen(((n > DEPTH) ? DEPTH : n) * 4, bq);
            expect_load(n, bq);
            start_load(n);
            if (bq.size() > 0) drive(bq, $urandom_range(0, 2), -1);
            wait_done(cyc);
        end
        repeat (3) @(negedge clk);
        chk("queues_drained", exp_data.size() + exp_done.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
